// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core, with the EX-stage front end.
// Holds the decoded instruction and applies stall and flush to it.
// Forwards operands from MEM and WB and builds the ALU A/B operands.
// Raises load_use when decode needs the result of a load that is still in EX.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [XLEN-1:0]  d_pc,
    input  logic [XLEN-1:0]  d_rs1_data,
    input  logic [XLEN-1:0]  d_rs2_data,
    input  logic [XLEN-1:0]  d_imm,
    input  logic [RADDR-1:0] d_rs1,
    input  logic [RADDR-1:0] d_rs2,
    input  logic [RADDR-1:0] d_rd,
    input  logic [2:0]       d_alu_ctrl,
    input  logic             d_a_src,
    input  logic             d_b_src,
    input  logic             d_reg_write,
    input  logic             d_mem_write,
    input  logic             d_mem_read,
    input  logic             d_branch,
    input  logic             d_jump,
    input  logic [RADDR-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [XLEN-1:0]  mem_alu_res,
    input  logic [RADDR-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [2:0]       alu_ctrl,
    output logic [XLEN-1:0]  store_data,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_write,
    output logic             ex_mem_read,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             load_use
);

    // One record holds the whole pipeline register, so a bubble is just all zeros.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic [2:0]       alu_ctrl;
        logic             a_src;
        logic             b_src;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic             branch;
        logic             jump;
    } idex_t;

    idex_t ex_q, ex_d;
    idex_t dec_s;
    logic [XLEN-1:0] fwd_a_s, fwd_b_s;

    // Pick the newest value of a source register.  MEM is newer than WB.
    // x0 is never forwarded, because its register-file value is already 0.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RADDR-1:0] rs,
        input logic [XLEN-1:0]  reg_val,
        input logic [RADDR-1:0] m_rd,
        input logic             m_we,
        input logic [XLEN-1:0]  m_val,
        input logic [RADDR-1:0] w_rd,
        input logic             w_we,
        input logic [XLEN-1:0]  w_val
    );
        logic [XLEN-1:0] r;
        if (m_we && (m_rd != {RADDR{1'b0}}) && (m_rd == rs)) begin
            r = m_val;
        end else if (w_we && (w_rd != {RADDR{1'b0}}) && (w_rd == rs)) begin
            r = w_val;
        end else begin
            r = reg_val;
        end
        return r;
    endfunction

    // Pack the decode inputs into the pipeline-register record.
    always_comb begin
        dec_s           = '0;
        dec_s.valid     = d_valid;
        dec_s.pc        = d_pc;
        dec_s.rs1_data  = d_rs1_data;
        dec_s.rs2_data  = d_rs2_data;
        dec_s.imm       = d_imm;
        dec_s.rs1       = d_rs1;
        dec_s.rs2       = d_rs2;
        dec_s.rd        = d_rd;
        dec_s.alu_ctrl  = d_alu_ctrl;
        dec_s.a_src     = d_a_src;
        dec_s.b_src     = d_b_src;
        dec_s.reg_write = d_reg_write;
        dec_s.mem_write = d_mem_write;
        dec_s.mem_read  = d_mem_read;
        dec_s.branch    = d_branch;
        dec_s.jump      = d_jump;
    end

    // Next state of the pipeline register.  Flush beats stall, and stall beats capture.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else begin
            ex_d = dec_s;
        end
    end

    // Pipeline register.  An asynchronous reset leaves a bubble in the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forward the operands and select the ALU inputs.  All paths are full width.
    always_comb begin
        fwd_a_s = fwd_sel(ex_q.rs1, ex_q.rs1_data, mem_rd, mem_reg_write, mem_alu_res,
                          wb_rd, wb_reg_write, wb_result);
        fwd_b_s = fwd_sel(ex_q.rs2, ex_q.rs2_data, mem_rd, mem_reg_write, mem_alu_res,
                          wb_rd, wb_reg_write, wb_result);
        if (ex_q.a_src) begin
            alu_a = ex_q.pc;
        end else begin
            alu_a = fwd_a_s;
        end
        if (ex_q.b_src) begin
            alu_b = ex_q.imm;
        end else begin
            alu_b = fwd_b_s;
        end
        store_data = fwd_b_s;
    end

    // Load-use hazard: decode reads the destination of a load that is still in EX.
    always_comb begin
        load_use = ex_q.mem_read && (ex_q.rd != {RADDR{1'b0}}) && d_valid &&
                   ((ex_q.rd == d_rs1) || (ex_q.rd == d_rs2));
    end

    assign alu_ctrl     = ex_q.alu_ctrl;
    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage.
// A behavioural model of the ID/EX slot is compared with the DUT on every falling edge.
// Directed vectors with literal expectations pin the model down.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, d_valid;
    logic [31:0] d_pc, d_rs1_data, d_rs2_data, d_imm;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [2:0]  d_alu_ctrl;
    logic        d_a_src, d_b_src, d_reg_write, d_mem_write, d_mem_read, d_branch, d_jump;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_alu_res, wb_result;
    logic [31:0] alu_a, alu_b, store_data, ex_pc, ex_imm;
    logic [2:0]  alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_write, ex_mem_read, ex_branch, ex_jump, load_use;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d_valid(d_valid),
        .d_pc(d_pc), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_imm(d_imm),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_alu_ctrl(d_alu_ctrl),
        .d_a_src(d_a_src), .d_b_src(d_b_src), .d_reg_write(d_reg_write),
        .d_mem_write(d_mem_write), .d_mem_read(d_mem_read), .d_branch(d_branch),
        .d_jump(d_jump), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_alu_res(mem_alu_res), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_result(wb_result), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .store_data(store_data), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
        .ex_mem_read(ex_mem_read), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .load_use(load_use)
    );

    always #5 clk = ~clk;

    // Model of the instruction that currently sits in EX.
    logic        m_valid, m_asrc, m_bsrc, m_rw, m_mw, m_mr, m_br, m_jp;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_ctrl;

    // Model: the instruction in EX is a bubble after reset or flush.
    // It stays the same on a stall.  Otherwise it is whatever decode presented.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            m_valid <= 1'b0; m_pc <= 32'd0; m_rs1d <= 32'd0; m_rs2d <= 32'd0; m_imm <= 32'd0;
            m_rs1 <= 5'd0; m_rs2 <= 5'd0; m_rd <= 5'd0; m_ctrl <= 3'd0; m_asrc <= 1'b0;
            m_bsrc <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_mr <= 1'b0; m_br <= 1'b0; m_jp <= 1'b0;
        end else if (!stall) begin
            m_valid <= d_valid; m_pc <= d_pc; m_rs1d <= d_rs1_data; m_rs2d <= d_rs2_data;
            m_imm <= d_imm; m_rs1 <= d_rs1; m_rs2 <= d_rs2; m_rd <= d_rd; m_ctrl <= d_alu_ctrl;
            m_asrc <= d_a_src; m_bsrc <= d_b_src; m_rw <= d_reg_write; m_mw <= d_mem_write;
            m_mr <= d_mem_read; m_br <= d_branch; m_jp <= d_jump;
        end
    end

    // Value of register rs as seen in EX: the newest in-flight write, or else the file value.
    function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] file_val);
        if (rs == 5'd0) return file_val;
        if (mem_reg_write && mem_rd == rs) return mem_alu_res;
        if (wb_reg_write && wb_rd == rs) return wb_result;
        return file_val;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT with the model once per cycle, on the falling edge.
    always @(negedge clk) begin
        chk("cyc_alu_a", alu_a, m_asrc ? m_pc : newest(m_rs1, m_rs1d));
        chk("cyc_alu_b", alu_b, m_bsrc ? m_imm : newest(m_rs2, m_rs2d));
        chk("cyc_store", store_data, newest(m_rs2, m_rs2d));
        chk("cyc_regs", {ex_pc, ex_imm} == {m_pc, m_imm} ? 32'd1 : 32'd0, 32'd1);
        chk("cyc_ctrl", {19'd0, alu_ctrl, ex_rd, ex_valid, ex_reg_write, ex_mem_write,
                         ex_mem_read, ex_branch, ex_jump},
                        {19'd0, m_ctrl, m_rd, m_valid, m_rw, m_mw, m_mr, m_br, m_jp});
        chk("cyc_load_use", {31'd0, load_use},
            {31'd0, m_mr && m_rd != 5'd0 && d_valid && (m_rd == d_rs1 || m_rd == d_rs2)});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [2:0] ctrl, input logic asrc,
                       input logic bsrc, input logic rw, input logic mr);
        d_valid = 1'b1; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd; d_rs1_data = v1; d_rs2_data = v2;
        d_imm = imm; d_pc = pc; d_alu_ctrl = ctrl; d_a_src = asrc; d_b_src = bsrc;
        d_reg_write = rw; d_mem_read = mr; d_mem_write = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        dec(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        d_valid = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_alu_res = 32'd0;
        wb_rd = 5'd0; wb_reg_write = 1'b0; wb_result = 32'd0;
        tick; tick;
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        rst = 1'b0;

        // add x3,x1,x2 with no hazards
        dec(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_rd", {27'd0, ex_rd}, 32'd3);
        chk("add_rw", {31'd0, ex_reg_write}, 32'd1);

        // Reset mid-cycle with d_reg_write still held: the stage clears without a clock edge.
        d_alu_ctrl = 3'b011;
        tick;
        chk("pre_rst_ctrl", {29'd0, alu_ctrl}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        tick;
        rst = 1'b0;

        // MEM forwarding wins over WB; WB is used once MEM stops writing.
        dec(5'd4, 5'd0, 5'd8, 32'h99, 32'd0, 32'd0, 32'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        mem_rd = 5'd4; mem_reg_write = 1'b1; mem_alu_res = 32'h11;
        wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h22;
        #1 chk("fwd_mem", alu_a, 32'h11);
        mem_reg_write = 1'b0;
        #1 chk("fwd_wb", alu_a, 32'h22);
        wb_reg_write = 1'b0;
        #1 chk("fwd_none", alu_a, 32'h99);

        // x0 is never forwarded.
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_alu_res = 32'hFF;
        #1 chk("x0_alu_b", alu_b, 32'd0);
        chk("x0_store", store_data, 32'd0);
        mem_reg_write = 1'b0;

        // With b_src=1, alu_b takes the immediate and store_data still takes the forwarded rs2.
        dec(5'd1, 5'd6, 5'd0, 32'd1, 32'h66, 32'h123, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        chk("imm_alu_b", alu_b, 32'h123);
        chk("imm_store", store_data, 32'h66);
        wb_rd = 5'd6; wb_reg_write = 1'b1; wb_result = 32'hABCD;
        #1 chk("store_fwd_wb", store_data, 32'hABCD);
        chk("imm_alu_b_fwd", alu_b, 32'h123);
        wb_reg_write = 1'b0;

        // Load-use: lw x5 in EX; decode reads x5.
        dec(5'd2, 5'd0, 5'd5, 32'd0, 32'd0, 32'd8, 32'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
        tick;
        dec(5'd5, 5'd9, 5'd6, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("lu_rs1", {31'd0, load_use}, 32'd1);
        d_valid = 1'b0;
        #1 chk("lu_invalid", {31'd0, load_use}, 32'd0);
        d_valid = 1'b1; d_rs1 = 5'd7; d_rs2 = 5'd5;
        #1 chk("lu_rs2", {31'd0, load_use}, 32'd1);
        d_rs2 = 5'd8;
        #1 chk("lu_nomatch", {31'd0, load_use}, 32'd0);
        d_rs2 = 5'd5;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("flush_mw", {31'd0, ex_mem_write}, 32'd0);
        chk("flush_lu", {31'd0, load_use}, 32'd0);

        // A load to x0 never raises load_use.
        dec(5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        d_rs1 = 5'd0; d_rs2 = 5'd0;
        #1 chk("lu_x0", {31'd0, load_use}, 32'd0);

        // Stall for 3 cycles while decode changes; then stall and flush together; then release.
        dec(5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 32'h100, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        d_branch = 1'b1;
        tick;
        chk("pcsel_alu_a", alu_a, 32'h100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dec(5'd3, 5'd4, 5'(10 + i), 32'd3, 32'd4, 32'd0, 32'h200 + 32'(i), 3'b010,
                1'b0, 1'b0, 1'b0, 1'b0);
            tick;
            chk("stall_pc", ex_pc, 32'h100);
            chk("stall_rd", {27'd0, ex_rd}, 32'd9);
            chk("stall_br", {31'd0, ex_branch}, 32'd1);
        end
        flush = 1'b1;
        tick;
        chk("sf_valid", {31'd0, ex_valid}, 32'd0);
        chk("sf_pc", ex_pc, 32'd0);
        stall = 1'b0; flush = 1'b0;
        dec(5'd1, 5'd2, 5'd12, 32'd1, 32'd2, 32'd0, 32'h300, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0);
        d_jump = 1'b1;
        tick;
        chk("rel_pc", ex_pc, 32'h300);
        chk("rel_rd", {27'd0, ex_rd}, 32'd12);
        chk("rel_jump", {31'd0, ex_jump}, 32'd1);

        d_valid = 1'b0;
        tick; tick;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
